// File: rtl/jtag_scan_ctrl.sv
// Command-driven JTAG scan sequencer: turns reset / IR scan / DR scan / idle-N commands
// into registered TMS/TDI streams on the shared TCK and captures TDO, parking the TAP in RTI.
module jtag_scan_ctrl #(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5
) (
   input  logic               TCK,
   input  logic               TRST,
   input  logic               CMD_VALID,
   output logic               CMD_READY,
   input  logic [1:0]         CMD_TYPE,
   input  logic [LEN_W-1:0]   CMD_LEN,
   input  logic [MAX_LEN-1:0] CMD_DATA,
   output logic               RSP_VALID,
   output logic               RSP_ERR,
   output logic [MAX_LEN-1:0] RSP_DATA,
   output logic               TMS_O,
   output logic               TDI_O,
   input  logic               TDO_I,
   output logic               BUSY
);

   localparam int IDX_W = $clog2(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] INIT_LAST = LEN_W'(5);

   typedef enum logic [3:0] {
      INIT, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN, DONE
   } state_e;

   typedef enum logic [1:0] {
      CMD_RESET = 2'd0, CMD_IR = 2'd1, CMD_DR = 2'd2, CMD_IDLE = 2'd3
   } cmd_e;

   state_e             state_q, state_d;
   cmd_e               type_q, type_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic [MAX_LEN-1:0] cap_q, cap_d;
   logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_err_q, rsp_err_d;
   logic               ready_q, ready_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic               rst_cmd_q, rst_cmd_d;
   logic               complete;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d     = state_q;
      type_d      = type_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      data_d      = data_q;
      cap_d       = cap_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      ready_d     = ready_q;
      rst_cmd_d   = rst_cmd_q;
      complete    = 1'b0;

      case (state_q)
         INIT: begin
            if (cnt_q == INIT_LAST) begin
               if (rst_cmd_q) begin
                  complete  = 1'b1;
                  rst_cmd_d = 1'b0;
               end else begin
                  state_d = IDLE;
                  ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + LEN_ONE;
            end
         end
         IDLE, DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
            if (CMD_VALID && ready_q) begin
               type_d  = cmd_e'(CMD_TYPE);
               len_d   = CMD_LEN;
               data_d  = CMD_DATA;
               cnt_d   = '0;
               cap_d   = '0;
               ready_d = 1'b0;
               if (type_d == CMD_RESET) begin
                  state_d   = INIT;
                  rst_cmd_d = 1'b1;
               end else if (CMD_LEN == '0 || CMD_LEN > LEN_MAX) begin
                  // Rejected lengths answer at once and never touch the TAP.
                  state_d     = DONE;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (type_q == CMD_IDLE) begin
               if (cnt_q == len_q - LEN_ONE) complete = 1'b1;
               else                          cnt_d = cnt_q + LEN_ONE;
            end else begin
               state_d = SEL_DR;
            end
         end
         SEL_DR:  state_d = (type_q == CMD_IR) ? SEL_IR : CAPTURE;
         SEL_IR:  state_d = CAPTURE;
         CAPTURE: begin
            state_d = SHIFT;
            cnt_d   = '0;
         end
         SHIFT: begin
            cap_d[cnt_q[IDX_W-1:0]] = TDO_I;
            if (cnt_q == len_q - LEN_ONE) state_d = EXIT1;
            else                          cnt_d   = cnt_q + LEN_ONE;
         end
         EXIT1:   state_d  = UPDATE;
         UPDATE:  complete = 1'b1;
         default: state_d  = INIT;
      endcase

      if (complete) begin
         state_d     = DONE;
         rsp_valid_d = 1'b1;
         ready_d     = 1'b1;
         rsp_data_d  = (type_q == CMD_IR || type_q == CMD_DR) ? cap_d : '0;
      end
   end

   // Pins are registered from the next state, so TMS/TDI line up with the state register.
   always_comb begin
      tms_d = 1'b0;
      tdi_d = 1'b0;
      case (state_d)
         INIT:   tms_d = (cnt_d < INIT_LAST);
         RUN:    tms_d = (type_d != CMD_IDLE);
         SEL_DR: tms_d = (type_d == CMD_IR);
         EXIT1:  tms_d = 1'b1;
         SHIFT: begin
            tms_d = (cnt_d == len_d - LEN_ONE);
            tdi_d = data_d[cnt_d[IDX_W-1:0]];
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge TCK) begin
      if (TRST) begin
         state_q     <= INIT;
         type_q      <= CMD_RESET;
         cnt_q       <= '0;
         len_q       <= '0;
         data_q      <= '0;
         cap_q       <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         ready_q     <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         rst_cmd_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         data_q      <= data_d;
         cap_q       <= cap_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         ready_q     <= ready_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         rst_cmd_q   <= rst_cmd_d;
      end
   end

   assign CMD_READY = ready_q;
   assign BUSY      = ~ready_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_ERR   = rsp_err_q;
   assign RSP_DATA  = rsp_data_q;
   assign TMS_O     = tms_q;
   assign TDI_O     = tdi_q;

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Bench for jtag_scan_ctrl: a bit-level TAP device (IR 4 bits, IDCODE 8'hF1, BYPASS) plus a
// command-level prediction of every pin per cycle, compared on each falling edge.
module tb_jtag_scan_ctrl;
   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;

   logic               TCK = 1'b0;
   logic               TRST = 1'b1;
   logic               CMD_VALID = 1'b0;
   logic [1:0]         CMD_TYPE = '0;
   logic [LEN_W-1:0]   CMD_LEN = '0;
   logic [MAX_LEN-1:0] CMD_DATA = '0;
   logic               CMD_READY, RSP_VALID, RSP_ERR, TMS_O, TDI_O, TDO_I, BUSY;
   logic [MAX_LEN-1:0] RSP_DATA;

   always #5 TCK = ~TCK;

   jtag_scan_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .TCK(TCK), .TRST(TRST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_TYPE(CMD_TYPE), .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA),
      .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_DATA(RSP_DATA),
      .TMS_O(TMS_O), .TDI_O(TDI_O), .TDO_I(TDO_I), .BUSY(BUSY)
   );

   // Device under the controller: standard 16-state TAP, TDO launched on the falling edge.
   typedef enum logic [3:0] {
      TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDDR,
      SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPDIR
   } tap_e;

   tap_e       tap_st = TLR;
   logic [3:0] ir     = 4'h7;
   logic [3:0] ir_sr  = '0;
   logic [7:0] id_sr  = '0;
   logic       bp     = 1'b0;
   logic       tdo_r  = 1'b0;

   function automatic tap_e tap_next(input tap_e s, input logic tms);
      case (s)
         TLR:     return tms ? TLR   : RTI;
         RTI:     return tms ? SELDR : RTI;
         SELDR:   return tms ? SELIR : CAPDR;
         CAPDR:   return tms ? EX1DR : SHDR;
         SHDR:    return tms ? EX1DR : SHDR;
         EX1DR:   return tms ? UPDDR : PDR;
         PDR:     return tms ? EX2DR : PDR;
         EX2DR:   return tms ? UPDDR : SHDR;
         UPDDR:   return tms ? SELDR : RTI;
         SELIR:   return tms ? TLR   : CAPIR;
         CAPIR:   return tms ? EX1IR : SHIR;
         SHIR:    return tms ? EX1IR : SHIR;
         EX1IR:   return tms ? UPDIR : PIR;
         PIR:     return tms ? EX2IR : PIR;
         EX2IR:   return tms ? UPDIR : SHIR;
         default: return tms ? SELDR : RTI;
      endcase
   endfunction

   always @(posedge TCK) begin
      case (tap_st)
         TLR:   ir <= 4'h7;
         CAPDR: if (ir == 4'h7) id_sr <= 8'hF1; else bp <= 1'b0;
         SHDR:  if (ir == 4'h7) id_sr <= {TDI_O, id_sr[7:1]}; else bp <= TDI_O;
         CAPIR: ir_sr <= 4'b0001;
         SHIR:  ir_sr <= {TDI_O, ir_sr[3:1]};
         UPDIR: ir <= ir_sr;
         default: ;
      endcase
      tap_st <= tap_next(tap_st, TMS_O);
   end

   always @(negedge TCK)
      tdo_r <= (tap_st == SHDR) ? ((ir == 4'h7) ? id_sr[0] : bp) :
               (tap_st == SHIR) ? ir_sr[0] : 1'b0;
   assign TDO_I = tdo_r;

   // Expected pins for one cycle; an empty queue means "parked in IDLE".
   typedef struct {
      logic        tms;
      logic        tdi;
      logic        ready;
      logic        rv;
      logic        re;
      logic [15:0] rd;
   } exp_t;

   exp_t        exp_q[$];
   bit          check_en  = 1'b0;
   logic [15:0] cur_rsp   = '0;
   logic [15:0] model_rsp = '0;
   logic [3:0]  model_ir  = 4'h7;
   logic [31:0] tms_hist  = '0;
   logic [31:0] tdi_hist  = '0;
   int          n_checks  = 0;
   int          n_err     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge TCK) begin : cmp_proc
      exp_t e;
      tms_hist = {tms_hist[30:0], TMS_O};
      tdi_hist = {tdi_hist[30:0], TDI_O};
      if (check_en) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cur_rsp = e.rd;
         end else begin
            e = '{tms: 1'b0, tdi: 1'b0, ready: 1'b1, rv: 1'b0, re: 1'b0, rd: cur_rsp};
         end
         check("tms", 32'(TMS_O), 32'(e.tms));
         check("tdi", 32'(TDI_O), 32'(e.tdi));
         check("cmd_ready", 32'(CMD_READY), 32'(e.ready));
         check("busy", 32'(BUSY), 32'(!e.ready));
         check("rsp_valid", 32'(RSP_VALID), 32'(e.rv));
         if (e.rv) check("rsp_err", 32'(RSP_ERR), 32'(e.re));
         check("rsp_data", 32'(RSP_DATA), 32'(e.rd));
      end
   end

   // Scan-level view of the device: what TDO returns over a whole scan.
   function automatic logic [15:0] predict_ir(input int n, input logic [15:0] tdi);
      logic [3:0]  cap = 4'b0001;
      logic [15:0] r   = '0;
      for (int i = 0; i < n; i++)
         if (i < 4) r[i] = cap[i]; else r[i] = tdi[i-4];
      return r;
   endfunction

   function automatic logic [15:0] predict_dr(input int n, input logic [15:0] tdi);
      logic [7:0]  idc = 8'hF1;
      logic [15:0] r   = '0;
      for (int i = 0; i < n; i++) begin
         if (model_ir == 4'h7) begin
            if (i < 8) r[i] = idc[i]; else r[i] = tdi[i-8];
         end else begin
            if (i == 0) r[i] = 1'b0; else r[i] = tdi[i-1];
         end
      end
      return r;
   endfunction

   int steps;

   task automatic push_step(input logic tms, input logic tdi);
      exp_t e;
      e = '{tms: tms, tdi: tdi, ready: 1'b0, rv: 1'b0, re: 1'b0, rd: model_rsp};
      exp_q.push_back(e);
      steps++;
   endtask

   task automatic release_trst();
      check("rst_tms", 32'(TMS_O), 32'd1);
      check("rst_tdi", 32'(TDI_O), 32'd0);
      check("rst_ready", 32'(CMD_READY), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd1);
      check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
      check("rst_rsp_err", 32'(RSP_ERR), 32'd0);
      check("rst_rsp_data", 32'(RSP_DATA), 32'd0);
      TRST      = 1'b0;
      model_rsp = '0;
      model_ir  = 4'h7;
      steps     = 0;
      for (int i = 0; i < 6; i++) push_step(i < 5, 1'b0);
      check_en = 1'b1;
      repeat (6) @(posedge TCK);
      #1;
      check("init_tms_seq", tms_hist[5:0], 6'b111110);
      check("init_ready_c7", 32'(CMD_READY), 32'd1);
   endtask

   // Offers a command, predicts every pin for cycles 1..K+1, returns in cycle K+1
   // (or in cycle 1+abort_after with TRST raised when abort_after > 0).
   task automatic send(input logic [1:0] typ, input int len, input logic [15:0] data,
                       input int abort_after);
      exp_t        e;
      logic [15:0] nxt;
      int          w;
      CMD_TYPE  = typ;
      CMD_LEN   = LEN_W'(len);
      CMD_DATA  = data;
      CMD_VALID = 1'b1;
      w = 0;
      while (CMD_READY !== 1'b1 && w < 50) begin
         @(posedge TCK);
         #1;
         w++;
      end
      if (CMD_READY !== 1'b1) begin
         n_checks++;
         n_err++;
         $display("FAIL accept_timeout: CMD_READY=%b, expected 1 within 50 cycles", CMD_READY);
         CMD_VALID = 1'b0;
         return;
      end
      @(posedge TCK);
      #1;
      CMD_VALID = 1'b0;
      steps = 0;
      if (typ != 2'd0 && (len == 0 || len > MAX_LEN)) begin
         e = '{tms: 1'b0, tdi: 1'b0, ready: 1'b0, rv: 1'b1, re: 1'b1, rd: model_rsp};
         exp_q.push_back(e);
         @(posedge TCK);
         #1;
         return;
      end
      case (typ)
         2'd0: begin
            for (int i = 0; i < 6; i++) push_step(i < 5, 1'b0);
            nxt = '0;
            model_ir = 4'h7;
         end
         2'd1, 2'd2: begin
            push_step(1'b1, 1'b0);
            if (typ == 2'd1) push_step(1'b1, 1'b0);
            push_step(1'b0, 1'b0);
            push_step(1'b0, 1'b0);
            for (int i = 0; i < len; i++) push_step(i == len - 1, data[i]);
            push_step(1'b1, 1'b0);
            push_step(1'b0, 1'b0);
            if (typ == 2'd1) begin
               nxt = predict_ir(len, data);
               model_ir = data[3:0];
            end else begin
               nxt = predict_dr(len, data);
            end
         end
         default: begin
            for (int i = 0; i < len; i++) push_step(1'b0, 1'b0);
            nxt = '0;
         end
      endcase
      e = '{tms: 1'b0, tdi: 1'b0, ready: 1'b1, rv: 1'b1, re: 1'b0, rd: nxt};
      exp_q.push_back(e);
      model_rsp = nxt;
      if (abort_after > 0) begin
         repeat (abort_after) @(posedge TCK);
         #1;
         TRST     = 1'b1;
         check_en = 1'b0;
         exp_q.delete();
         return;
      end
      repeat (steps) @(posedge TCK);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge TCK);
      #1;
      release_trst();

      send(2'd1, 4, 16'h0007, 0);
      check("ir_tms_seq", tms_hist[9:0], 10'b1100000110);
      check("ir_tdi_seq", tdi_hist[9:0], 10'b0000111000);
      check("ir_rsp_valid_c11", 32'(RSP_VALID), 32'd1);
      check("ir_capture", 32'(RSP_DATA), 32'h0001);

      send(2'd2, 8, 16'h0000, 0);
      check("idcode", 32'(RSP_DATA), 32'h00F1);
      check("idcode_err", 32'(RSP_ERR), 32'd0);

      repeat (2) @(posedge TCK);
      #1;
      send(2'd1, 4, 16'h000F, 0);
      send(2'd2, 8, 16'h00A5, 0);
      check("bypass", 32'(RSP_DATA), 32'h004A);

      send(2'd2, 0, 16'h1234, 0);
      send(2'd2, 17, 16'h1234, 0);
      check("err_tap_rti", 32'(tap_st), 32'(RTI));
      send(2'd2, 8, 16'h003C, 0);

      send(2'd3, 3, 16'h0000, 0);
      send(2'd3, 0, 16'h0000, 0);
      send(2'd3, 1, 16'h0000, 0);

      send(2'd0, 0, 16'h0000, 0);
      send(2'd2, 1, 16'h0000, 0);
      send(2'd2, 16, 16'hBEEF, 0);
      check("dr_max_len", 32'(RSP_DATA), 32'hEFF1);

      send(2'd1, 4, 16'h000F, 0);
      send(2'd2, 8, 16'h0055, 5);
      @(posedge TCK);
      #1;
      release_trst();
      send(2'd2, 8, 16'h0000, 0);
      check("idcode_after_abort", 32'(RSP_DATA), 32'h00F1);

      repeat (3) @(posedge TCK);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
